// File: rtl/spi_pixel_receiver.sv
// spi_pixel_receiver
//   SPI mode-0 slave that receives grayscale pixel bytes from the MCU.
//   - SCK/MOSI/CS_n are synchronised into clk and bytes are deserialised MSB first.
//   - Completed bytes go through a small FIFO onto a valid/ready pixel stream.
//   - One IMAGE_SIZE-byte frame is tracked per CS session, with frame-done and overflow flags.
//   - MISO echoes the previously completed byte, MSB first.
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   spi_sclk_i          SPI clock (async, <= clk/8)
//   spi_mosi_i          SPI data in (async)
//   spi_cs_n_i          SPI chip select, active low (async)
//   spi_miso_o          echo of the previous byte
//   pix_data_o          head-of-FIFO pixel (0 when empty)
//   pix_valid_o         pix_data_o valid
//   pix_ready_i         consumer accepts the pixel this cycle
//   frame_start_o       1-cycle pulse on a synchronised CS fall
//   frame_done_o        IMAGE_SIZE bytes received this session (held until next CS fall)
//   overflow_o          sticky: a byte was lost because the FIFO was full
//   byte_count_o        bytes accepted into the FIFO this session
module spi_pixel_receiver #(
    parameter int unsigned RGB_SIZE   = 8,
    parameter int unsigned IMAGE_SIZE = 256,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CNT_W     = $clog2(IMAGE_SIZE + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spi_sclk_i,
    input  logic                spi_mosi_i,
    input  logic                spi_cs_n_i,
    output logic                spi_miso_o,
    output logic [RGB_SIZE-1:0] pix_data_o,
    output logic                pix_valid_o,
    input  logic                pix_ready_i,
    output logic                frame_start_o,
    output logic                frame_done_o,
    output logic                overflow_o,
    output logic [CNT_W-1:0]    byte_count_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned BitW = $clog2(RGB_SIZE);
    localparam logic [PtrW:0] FifoFull = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

    // Synchronisers; the third stage on SCK and CS_n is only for edge detection.
    logic sclk_q1, sclk_q2, sclk_q3;
    logic mosi_q1, mosi_q2;
    logic cs_n_q1, cs_n_q2, cs_n_q3;

    state_e                state_q, state_d;
    logic [RGB_SIZE-1:0]   shift_q, shift_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  strobe_q, strobe_d;
    logic [RGB_SIZE-1:0]   last_byte_q, last_byte_d;
    logic [RGB_SIZE-1:0]   echo_q, echo_d;
    logic [CNT_W-1:0]      byte_count_q, byte_count_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overflow_q, overflow_d;
    logic                  frame_start_q, frame_start_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]         count_q, count_d;
    logic [RGB_SIZE-1:0]   mem_q [FIFO_DEPTH];

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_active;
    logic fifo_we, fifo_re, fifo_full;

    assign sclk_rise = sclk_q2 & ~sclk_q3;
    assign sclk_fall = ~sclk_q2 & sclk_q3;
    assign cs_fall   = ~cs_n_q2 & cs_n_q3;
    assign cs_rise   = cs_n_q2 & ~cs_n_q3;
    assign cs_active = ~cs_n_q2;

    assign pix_valid_o = (count_q != '0);
    assign fifo_full   = (count_q == FifoFull);
    assign fifo_re     = pix_valid_o & pix_ready_i;

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        strobe_d      = 1'b0;
        last_byte_d   = last_byte_q;
        echo_d        = echo_q;
        byte_count_d  = byte_count_q;
        frame_done_d  = frame_done_q;
        overflow_d    = overflow_q;
        frame_start_d = 1'b0;
        fifo_we       = 1'b0;

        if (cs_active && sclk_rise) begin
            shift_d = {shift_q[RGB_SIZE-2:0], mosi_q2};
            if (bit_cnt_q == BitW'(RGB_SIZE - 1)) begin
                bit_cnt_d = '0;
                strobe_d  = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + BitW'(1);
            end
        end

        // The fall that ends a byte (bit_cnt back at 0) must not shift: the echo
        // register has just been reloaded with the next byte to send.
        if (cs_active && sclk_fall && (bit_cnt_q != '0)) begin
            echo_d = {echo_q[RGB_SIZE-2:0], 1'b0};
        end

        if (strobe_q) begin
            last_byte_d = shift_q;
            echo_d      = shift_q;
        end

        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d       = StRecv;
                    frame_start_d = 1'b1;
                    byte_count_d  = '0;
                    overflow_d    = 1'b0;
                    frame_done_d  = 1'b0;
                    bit_cnt_d     = '0;
                    echo_d        = last_byte_q;
                end
            end
            StRecv: begin
                if (strobe_q) begin
                    // A read in the same cycle frees the slot, so a full FIFO can still accept.
                    if (!fifo_full || fifo_re) begin
                        fifo_we      = 1'b1;
                        byte_count_d = byte_count_q + CNT_W'(1);
                        if (byte_count_q == CNT_W'(IMAGE_SIZE - 1)) begin
                            state_d      = StDone;
                            frame_done_d = 1'b1;
                        end
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (cs_rise) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                end
            end
            StDone: begin
                if (cs_rise) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        wr_ptr_d = fifo_we ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = fifo_re ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (fifo_we && !fifo_re) begin
            count_d = count_q + (PtrW + 1)'(1);
        end else if (!fifo_we && fifo_re) begin
            count_d = count_q - (PtrW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q1       <= 1'b0;
            sclk_q2       <= 1'b0;
            sclk_q3       <= 1'b0;
            mosi_q1       <= 1'b0;
            mosi_q2       <= 1'b0;
            cs_n_q1       <= 1'b1;
            cs_n_q2       <= 1'b1;
            cs_n_q3       <= 1'b1;
            state_q       <= StIdle;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            strobe_q      <= 1'b0;
            last_byte_q   <= '0;
            echo_q        <= '0;
            byte_count_q  <= '0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
            frame_start_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            sclk_q1       <= spi_sclk_i;
            sclk_q2       <= sclk_q1;
            sclk_q3       <= sclk_q2;
            mosi_q1       <= spi_mosi_i;
            mosi_q2       <= mosi_q1;
            cs_n_q1       <= spi_cs_n_i;
            cs_n_q2       <= cs_n_q1;
            cs_n_q3       <= cs_n_q2;
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            strobe_q      <= strobe_d;
            last_byte_q   <= last_byte_d;
            echo_q        <= echo_d;
            byte_count_q  <= byte_count_d;
            frame_done_q  <= frame_done_d;
            overflow_q    <= overflow_d;
            frame_start_q <= frame_start_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage needs no reset: pix_data_o is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (fifo_we) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign pix_data_o    = pix_valid_o ? mem_q[rd_ptr_q] : '0;
    assign spi_miso_o    = echo_q[RGB_SIZE-1];
    assign frame_start_o = frame_start_q;
    assign frame_done_o  = frame_done_q;
    assign overflow_o    = overflow_q;
    assign byte_count_o  = byte_count_q;

endmodule

// File: tb/tb_spi_pixel_receiver.sv
// tb_spi_pixel_receiver
//   Directed bench for spi_pixel_receiver: drives SPI mode-0 at clk/8 and checks the
//   pixel stream, frame flags, byte count and MISO echo against hand-computed values.
module tb_spi_pixel_receiver;

    localparam int unsigned CntW = 9;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            spi_sclk, spi_mosi, spi_cs_n, spi_miso;
    logic [7:0]      pix_data;
    logic            pix_valid, pix_ready;
    logic            frame_start, frame_done, overflow;
    logic [CntW-1:0] byte_count;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int rise_cyc = 0;
    int first_valid_cyc = 0;
    int valid_hi_cnt = 0;
    int fs_count = 0;
    logic [7:0] got_q [$];
    logic       valid_prev = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] data_prev = '0;

    spi_pixel_receiver #(
        .RGB_SIZE  (8),
        .IMAGE_SIZE(256),
        .FIFO_DEPTH(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_sclk_i   (spi_sclk),
        .spi_mosi_i   (spi_mosi),
        .spi_cs_n_i   (spi_cs_n),
        .spi_miso_o   (spi_miso),
        .pix_data_o   (pix_data),
        .pix_valid_o  (pix_valid),
        .pix_ready_i  (pix_ready),
        .frame_start_o(frame_start),
        .frame_done_o (frame_done),
        .overflow_o   (overflow),
        .byte_count_o (byte_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stream monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
            valid_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(pix_valid), 32'd1);
                chk("hold_data", 32'(pix_data), 32'(data_prev));
            end
            if (pix_valid && !valid_prev) first_valid_cyc = cyc;
            if (pix_valid) valid_hi_cnt++;
            if (pix_valid && pix_ready) got_q.push_back(pix_data);
            if (frame_start) fs_count++;
            stall_prev = pix_valid && !pix_ready;
            valid_prev = pix_valid;
            data_prev  = pix_data;
        end
    end

    function automatic logic [31:0] got_at(input int i);
        return (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends the n low bits of b MSB first; returns the MISO bits seen before each rise.
    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] miso_b);
        miso_b = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = b[i];
            spi_sclk = 1'b0;
            wait_clk(4);
            miso_b   = {miso_b[6:0], spi_miso};
            spi_sclk = 1'b1;
            rise_cyc = cyc;
            wait_clk(4);
        end
        spi_sclk = 1'b0;
        wait_clk(4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [7:0] dummy;
        send_bits(b, 8, dummy);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic cs_high();
        spi_cs_n = 1'b1;
        wait_clk(6);
    endtask

    initial begin
        int fs0;
        int hi0;
        logic [7:0] m1, m2;

        rst_n     = 1'b0;
        spi_sclk  = 1'b0;
        spi_mosi  = 1'b0;
        spi_cs_n  = 1'b1;
        pix_ready = 1'b0;

        // 1: reset with SCK toggling, then an idle CS-high period
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 spi_sclk = ~spi_sclk;
        end
        @(negedge clk);
        chk("rst_valid", 32'(pix_valid), 32'd0);
        chk("rst_data", 32'(pix_data), 32'd0);
        chk("rst_fstart", 32'(frame_start), 32'd0);
        chk("rst_fdone", 32'(frame_done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_count", 32'(byte_count), 32'd0);
        chk("rst_miso", 32'(spi_miso), 32'd0);
        wait_clk(1);
        spi_sclk = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            spi_sclk = ~spi_sclk;
            wait_clk(2);
        end
        spi_sclk = 1'b0;
        wait_clk(4);
        chk("idle_fstart", 32'(fs_count), 32'd0);
        chk("idle_valid", 32'(pix_valid), 32'd0);
        chk("idle_count", 32'(byte_count), 32'd0);

        // 2: single byte 0xA5, latency and one-cycle valid
        pix_ready = 1'b1;
        got_q.delete();
        fs0 = fs_count;
        cs_low();
        hi0 = valid_hi_cnt;
        send_byte(8'hA5);
        chk("t2_latency", 32'(first_valid_cyc - rise_cyc), 32'd4);
        chk("t2_valid_len", 32'(valid_hi_cnt - hi0), 32'd1);
        chk("t2_nbytes", 32'(got_q.size()), 32'd1);
        chk("t2_data", got_at(0), 32'hA5);
        chk("t2_count", 32'(byte_count), 32'd1);
        cs_high();
        chk("t2_fstart", 32'(fs_count - fs0), 32'd1);

        // 3: stalled consumer, 5 bytes into a 4-entry FIFO
        pix_ready = 1'b0;
        got_q.delete();
        cs_low();
        chk("t3_count0", 32'(byte_count), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i));
            if (i == 4) chk("t3_ovf_at4", 32'(overflow), 32'd0);
        end
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_count", 32'(byte_count), 32'd4);
        chk("t3_head", 32'(pix_data), 32'h01);
        pix_ready = 1'b1;
        wait_clk(8);
        chk("t3_nbytes", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t3_order", got_at(i), 32'(i + 1));
        cs_high();

        // 4: full frame plus one extra byte
        got_q.delete();
        cs_low();
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            if (i == 254) chk("t4_done_255", 32'(frame_done), 32'd0);
        end
        chk("t4_done_256", 32'(frame_done), 32'd1);
        chk("t4_count_256", 32'(byte_count), 32'd256);
        send_byte(8'hEE);
        chk("t4_ovf_257", 32'(overflow), 32'd0);
        chk("t4_count_257", 32'(byte_count), 32'd256);
        chk("t4_nbytes", 32'(got_q.size()), 32'd256);
        for (int i = 0; i < 256; i++) chk("t4_data", got_at(i), 32'(i));
        cs_high();
        chk("t4_done_hold", 32'(frame_done), 32'd1);

        // 5: partial byte discarded at CS rise
        got_q.delete();
        cs_low();
        chk("t5_done_clr", 32'(frame_done), 32'd0);
        send_bits(8'h15, 5, m1);
        cs_high();
        fs0 = fs_count;
        cs_low();
        send_byte(8'h3C);
        cs_high();
        chk("t5_fstart", 32'(fs_count - fs0), 32'd1);
        chk("t5_nbytes", 32'(got_q.size()), 32'd1);
        chk("t5_data", got_at(0), 32'h3C);

        // Asynchronous reset in the middle of a byte
        pix_ready = 1'b0;
        cs_low();
        send_byte(8'h77);
        send_bits(8'h05, 3, m1);
        chk("mr_valid_pre", 32'(pix_valid), 32'd1);
        chk("mr_count_pre", 32'(byte_count), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(pix_valid), 32'd0);
        chk("mr_data", 32'(pix_data), 32'd0);
        chk("mr_count", 32'(byte_count), 32'd0);
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        fs0 = fs_count;
        wait_clk(6);
        chk("mr_no_fstart", 32'(fs_count - fs0), 32'd0);

        // 6: MISO echo of the previous byte
        pix_ready = 1'b1;
        got_q.delete();
        cs_low();
        send_bits(8'h12, 8, m1);
        send_bits(8'h34, 8, m2);
        cs_high();
        chk("t6_echo1", 32'(m1), 32'h00);
        chk("t6_echo2", 32'(m2), 32'h12);
        chk("t6_data1", got_at(0), 32'h12);
        chk("t6_data2", got_at(1), 32'h34);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
